// File: rtl/pwm_tone_bank.sv
// pwm_tone_bank: eight square-wave voices driven from a shared prescaler tick.
// The voices are mixed into a 6-bit sample, and a 63-step PWM carrier turns
// that sample into a 1-bit audio stream.
// Optional feature: define PWM_TONE_SHADOW_EN to give each voice shadow copies
// of its volume and half-period. Writes then take effect only at the next wrap.
module pwm_tone_bank #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pwm_reg0,
    input  logic [15:0] pwm_reg1,
    input  logic [15:0] pwm_reg2,
    input  logic [15:0] pwm_reg3,
    input  logic [15:0] pwm_reg4,
    input  logic [15:0] pwm_reg5,
    input  logic [15:0] pwm_reg6,
    input  logic [15:0] pwm_reg7,
    output logic [7:0]  tone_out,
    output logic [5:0]  sample,
    output logic        sample_strobe,
    output logic        audio_out
);
    localparam int               PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [5:0]       CAR_LAST = 6'd62;

    logic [15:0] reg_a [8];
    assign reg_a[0] = pwm_reg0;
    assign reg_a[1] = pwm_reg1;
    assign reg_a[2] = pwm_reg2;
    assign reg_a[3] = pwm_reg3;
    assign reg_a[4] = pwm_reg4;
    assign reg_a[5] = pwm_reg5;
    assign reg_a[6] = pwm_reg6;
    assign reg_a[7] = pwm_reg7;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [11:0]      cnt_q [8];
    logic [11:0]      cnt_d [8];
    logic [7:0]       sq_q, sq_d;
    logic [7:0]       active;
    logic [11:0]      p_eff [8];
    logic [2:0]       vol_eff [8];
    logic [5:0]       sample_q, sample_d;
    logic [5:0]       car_q, car_d;
    logic [5:0]       duty_q, duty_d;
    logic             strobe_q, strobe_d;
    logic             audio_q, audio_d;

`ifdef PWM_TONE_SHADOW_EN
    logic [11:0] p_sh_q [8];
    logic [11:0] p_sh_d [8];
    logic [2:0]  vol_sh_q [8];
    logic [2:0]  vol_sh_d [8];
`endif

    // Prescaler: free-running count with a one-cycle tick on its last state.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Select the volume and half-period each voice acts on, and decide whether the voice is running.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
`ifdef PWM_TONE_SHADOW_EN
            p_eff[n]   = p_sh_q[n];
            vol_eff[n] = vol_sh_q[n];
`else
            p_eff[n]   = reg_a[n][11:0];
            vol_eff[n] = reg_a[n][14:12];
`endif
            active[n] = reg_a[n][15] && (p_eff[n] != 12'd0);
        end
    end

    // Voice dividers. An idle voice is forced to zero. The >= compare makes a
    // shortened period wrap on the next tick.
    always_comb begin
        logic wrap;
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        wrap = 1'b0;
        sq_d = sq_q;
        for (int n = 0; n < 8; n++) begin
            wrap     = 1'b0;
            cnt_d[n] = cnt_q[n];
`ifdef PWM_TONE_SHADOW_EN
            p_sh_d[n]   = p_sh_q[n];
            vol_sh_d[n] = vol_sh_q[n];
`endif
            if (!active[n]) begin
                cnt_d[n] = '0;
                sq_d[n]  = 1'b0;
            end else if (tick) begin
                if (cnt_q[n] >= p_eff[n] - 12'd1) begin
                    wrap     = 1'b1;
                    cnt_d[n] = '0;
                    sq_d[n]  = ~sq_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + 12'd1;
                end
            end
`ifdef PWM_TONE_SHADOW_EN
            if (!active[n] || wrap) begin
                p_sh_d[n]   = reg_a[n][11:0];
                vol_sh_d[n] = reg_a[n][14:12];
            end
`endif
        end
    end

    // Mixer: sum the volumes of the voices whose square wave is currently high.
    always_comb begin
        sample_d = '0;
        for (int n = 0; n < 8; n++) begin
            if (sq_q[n]) begin
                sample_d = sample_d + {3'b000, vol_eff[n]};
            end
        end
    end

    // Carrier: a 63-state counter that latches the duty cycle on each restart.
    always_comb begin
        car_d    = (car_q == CAR_LAST) ? 6'd0 : car_q + 6'd1;
        duty_d   = (car_q == 6'd0) ? sample_q : duty_q;
        strobe_d = (car_q == 6'd0);
        audio_d  = (car_q < duty_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge.
        if (rst) begin
            pre_q <= '0;
            // NOTE: the per-voice counters are a small register array, not a
            // RAM, so they are cleared element by element on reset.
            for (int n = 0; n < 8; n++) begin
                cnt_q[n] <= '0;
            end
            sq_q     <= '0;
            sample_q <= '0;
            car_q    <= '0;
            duty_q   <= '0;
            strobe_q <= 1'b0;
            audio_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            for (int n = 0; n < 8; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            sq_q     <= sq_d;
            sample_q <= sample_d;
            car_q    <= car_d;
            duty_q   <= duty_d;
            strobe_q <= strobe_d;
            audio_q  <= audio_d;
        end
    end

`ifdef PWM_TONE_SHADOW_EN
    // Shadow volume and half-period per voice. They are cleared on reset and reload while the voice is idle.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            if (rst) begin
                p_sh_q[n]   <= '0;
                vol_sh_q[n] <= '0;
            end else begin
                p_sh_q[n]   <= p_sh_d[n];
                vol_sh_q[n] <= vol_sh_d[n];
            end
        end
    end
`endif

    assign tone_out      = sq_q;
    assign sample        = sample_q;
    assign sample_strobe = strobe_q;
    assign audio_out     = audio_q;

endmodule

// File: tb/tb_pwm_tone_bank.sv
// Testbench for pwm_tone_bank. A behavioural model is stepped on every clock
// and compared with the DUT on every falling edge. Directed sections pin
// hand-computed values: half-periods, mixed levels, carrier duty and reset timing.
module tb_pwm_tone_bank;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] regs [8];
    logic [7:0]  tone_out;
    logic [5:0]  sample;
    logic        sample_strobe;
    logic        audio_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state, held as plain integers.
    int m_pre;
    int m_cnt [8];
    int m_sq  [8];
    int m_shp [8];
    int m_shv [8];
    int m_sample, m_car, m_duty, m_strobe, m_audio;

    pwm_tone_bank #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .pwm_reg0      (regs[0]),
        .pwm_reg1      (regs[1]),
        .pwm_reg2      (regs[2]),
        .pwm_reg3      (regs[3]),
        .pwm_reg4      (regs[4]),
        .pwm_reg5      (regs[5]),
        .pwm_reg6      (regs[6]),
        .pwm_reg7      (regs[7]),
        .tone_out      (tone_out),
        .sample        (sample),
        .sample_strobe (sample_strobe),
        .audio_out     (audio_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_vol(int n);
`ifdef PWM_TONE_SHADOW_EN
        return m_shv[n];
`else
        return int'(regs[n][14:12]);
`endif
    endfunction

    function automatic int model_period(int n);
`ifdef PWM_TONE_SHADOW_EN
        return m_shp[n];
`else
        return int'(regs[n][11:0]);
`endif
    endfunction

    // Reference model: the voice, mixer and carrier rules, applied once per clock.
    always @(posedge clk) begin
        bit tick;
        bit act;
        bit wrap;
        int mix;
        int p;
        if (rst) begin
            m_pre = 0;
            for (int n = 0; n < 8; n++) begin
                m_cnt[n] = 0; m_sq[n] = 0; m_shp[n] = 0; m_shv[n] = 0;
            end
            m_sample = 0; m_car = 0; m_duty = 0; m_strobe = 0; m_audio = 0;
        end else begin
            tick = (m_pre == CLK_DIV - 1);
            mix  = 0;
            for (int n = 0; n < 8; n++) begin
                if (m_sq[n] != 0) mix += model_vol(n);
            end
            for (int n = 0; n < 8; n++) begin
                p    = model_period(n);
                act  = regs[n][15] && (p != 0);
                wrap = 1'b0;
                if (!act) begin
                    m_cnt[n] = 0;
                    m_sq[n]  = 0;
                end else if (tick) begin
                    if (m_cnt[n] >= p - 1) begin
                        m_cnt[n] = 0;
                        m_sq[n]  = 1 - m_sq[n];
                        wrap     = 1'b1;
                    end else begin
                        m_cnt[n]++;
                    end
                end
                if (!act || wrap) begin
                    m_shp[n] = int'(regs[n][11:0]);
                    m_shv[n] = int'(regs[n][14:12]);
                end
            end
            m_strobe = (m_car == 0) ? 1 : 0;
            m_audio  = (m_car < m_duty) ? 1 : 0;
            if (m_car == 0) m_duty = m_sample;
            m_car    = (m_car + 1) % 63;
            m_sample = mix;
            m_pre    = (m_pre + 1) % CLK_DIV;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        int mt;
        if (cmp_en) begin
            mt = 0;
            for (int n = 0; n < 8; n++) mt |= (m_sq[n] << n);
            check("model_tone_out", int'(tone_out), mt);
            check("model_sample", int'(sample), m_sample);
            check("model_sample_strobe", int'(sample_strobe), m_strobe);
            check("model_audio_out", int'(audio_out), m_audio);
        end
    end

    // Call on a falling edge. Holds rst high across exactly one rising edge.
    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_toggle(input int idx, input int limit, output int cycles, output bit ok);
        logic prev;
        prev   = tone_out[idx];
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (tone_out[idx] !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int n = 0; n < 8; n++) regs[n] = v;
    endtask

    initial begin
        int  last, toggles, cyc, count, prev_sample;
        logic prev_tone, prev_hi;
        bit  ok, found;
        logic [15:0] v;
        int  r, p, idx;

        set_all(16'h0000);
        rst = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset_tone_out", int'(tone_out), 0);
        check("reset_sample", int'(sample), 0);
        check("reset_sample_strobe", int'(sample_strobe), 0);
        check("reset_audio_out", int'(audio_out), 0);

        // Voice 0 alone with P=3: a half-period of 12 clocks and a sample level of 7.
        @(negedge clk);
        regs[0] = 16'hF003;
        rst     = 1'b0;
        last = -1; toggles = 0; prev_tone = 1'b0; prev_hi = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            check("t1_upper_voices_quiet", int'(tone_out[7:1]), 0);
            check("t1_sample_level", int'(sample), prev_hi ? 7 : 0);
            if (tone_out[0] !== prev_tone) begin
                toggles++;
                if (last >= 0) check("t1_half_period", k - last, 12);
                last      = k;
                prev_tone = tone_out[0];
            end
            prev_hi = tone_out[0];
        end
        check("t1_toggle_count", toggles, 6);

        // All voices at P=1: in phase, 8-clock period, and a full-scale sample of 56.
        set_all(16'hF001);
        pulse_rst();
        last = -1; toggles = 0; prev_tone = 1'b0; prev_hi = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("t2_in_phase", int'(tone_out == 8'h00 || tone_out == 8'hFF), 1);
            check("t2_sample_level", int'(sample), prev_hi ? 56 : 0);
            if (tone_out[0] !== prev_tone) begin
                toggles++;
                if (last >= 0) check("t2_half_period", k - last, 4);
                last      = k;
                prev_tone = tone_out[0];
            end
            prev_hi = tone_out[0];
        end
        check("t2_toggle_count", toggles, 10);
        // Find a carrier restart that latches 56, then count high cycles over one carrier period.
        found = 1'b0;
        prev_sample = int'(sample);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (sample_strobe && prev_sample == 56) begin
                found = 1'b1;
                break;
            end
            prev_sample = int'(sample);
        end
        if (found) begin
            count = 0;
            for (int k = 0; k < 63; k++) begin
                @(negedge clk);
                if (audio_out) count++;
            end
            check("t2_audio_high_count", count, 56);
        end else begin
            check("t2_strobe_with_56_timeout", 0, 1);
        end

        // A voice with P=0, then with enable=0, stays silent and adds nothing to the mix.
        set_all(16'h0000);
        regs[0] = 16'hF001;
        regs[2] = 16'h9000;
        pulse_rst();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) regs[2] = 16'h1005;
            prev_hi = tone_out[0];
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                check("t3_voice2_silent", int'(tone_out[2]), 0);
                check("t3_sample_level", int'(sample), prev_hi ? 7 : 0);
                prev_hi = tone_out[0];
            end
        end

        // Mid-period change of P from 10 to 2 when cnt=4.
        set_all(16'h0000);
        regs[0] = 16'hF00A;
        pulse_rst();
        wait_toggle(0, 200, cyc, ok);
        if (!ok) check("t4_first_toggle_timeout", 0, 1);
        wait_toggle(0, 200, cyc, ok);
        if (ok) check("t4_steady_half_period", cyc, 40);
        else    check("t4_steady_toggle_timeout", 0, 1);
        repeat (16) @(negedge clk);
        regs[0] = 16'hF002;
        wait_toggle(0, 200, cyc, ok);
`ifdef PWM_TONE_SHADOW_EN
        if (ok) check("t4_half_period_after_write", cyc + 16, 40);
`else
        if (ok) check("t4_half_period_after_write", cyc + 16, 20);
`endif
        else    check("t4_after_write_timeout", 0, 1);
        wait_toggle(0, 200, cyc, ok);
        if (ok) check("t4_new_half_period", cyc, 8);
        else    check("t4_new_period_timeout", 0, 1);

        // A one-clock reset while the sample is 21, then timing after release.
        set_all(16'h0000);
        regs[0] = 16'hF001; regs[1] = 16'hF001; regs[2] = 16'hF001;
        pulse_rst();
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sample == 6'd21) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("t5_sample21_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_tone_out", int'(tone_out), 0);
        check("t5_rst_sample", int'(sample), 0);
        check("t5_rst_sample_strobe", int'(sample_strobe), 0);
        check("t5_rst_audio_out", int'(audio_out), 0);
        @(negedge clk);
        check("t5_first_strobe", int'(sample_strobe), 1);
        check("t5_tone_clock0", int'(tone_out), 0);
        @(negedge clk);
        check("t5_strobe_clock1", int'(sample_strobe), 0);
        check("t5_tone_clock1", int'(tone_out), 0);
        @(negedge clk);
        check("t5_tone_clock2", int'(tone_out), 0);
        @(negedge clk);
        check("t5_first_tick_toggle", int'(tone_out), 8'h07);

        // Random register writes and occasional resets, checked by the model.
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 7);
                r   = $urandom_range(0, 9);
                if (r == 0)      p = 0;
                else if (r == 9) p = $urandom_range(0, 4095);
                else             p = $urandom_range(1, 6);
                v[15]    = ($urandom_range(0, 5) != 0);
                v[14:12] = 3'($urandom_range(0, 7));
                v[11:0]  = 12'(p);
                regs[idx] = v;
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
